// File: rtl/audio_pkg.sv
// Shared constants, AGC state type and shift clamp helper for the audio output path.
// Latency: none (declarations only).
// Backpressure: none.
package audio_pkg;

    localparam int OUT_WIDTH   = 16;
    localparam int IN_WIDTH    = 48;
    localparam int SHIFT_WIDTH = 6;
    localparam int MAG_WIDTH   = 17;

    // Saturation limits of the 16-bit signed output, expressed at stage-1 width.
    localparam logic signed [IN_WIDTH-1:0] SAT_MAX = 48'sd32767;
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = -48'sd32768;

    // Peak magnitudes are capped at 2^16 so the tracker stays 17 bits wide.
    localparam logic signed [IN_WIDTH-1:0] PEAK_CAP_POS = 48'sd65536;
    localparam logic signed [IN_WIDTH-1:0] PEAK_CAP_NEG = -48'sd65536;
    localparam logic [MAG_WIDTH-1:0]       PEAK_CAP     = 17'd65536;

    // A window whose peak stays below this is quiet enough to earn more gain.
    localparam logic [MAG_WIDTH-1:0] LOW_THRESH = 17'd8192;

    typedef enum logic {
        TRACK = 1'b0,
        EVAL  = 1'b1
    } agc_state_t;

    function automatic logic [SHIFT_WIDTH-1:0] clamp_shift(
        input logic [SHIFT_WIDTH-1:0] s,
        input logic [SHIFT_WIDTH-1:0] lo,
        input logic [SHIFT_WIDTH-1:0] hi
    );
        if (s < lo)
            return lo;
        else if (s > hi)
            return hi;
        else
            return s;
    endfunction

endpackage

// File: rtl/sat_shifter.sv
// Arithmetic right shift of a 48-bit result, then saturation to 16 bits.
// Latency: 2 cycles from result_valid_in to audio_valid_out.
// Backpressure: none; every valid pulse (including back-to-back) yields one output.
module sat_shifter
    import audio_pkg::*;
(
    input  logic                   audio_clk,
    input  logic                   rst_in,
    input  logic [IN_WIDTH-1:0]    result_in,
    input  logic                   result_valid_in,
    input  logic [SHIFT_WIDTH-1:0] shift_in,
    output logic [OUT_WIDTH-1:0]   audio_out,
    output logic                   audio_valid_out,
    output logic                   clip_out,
    output logic [MAG_WIDTH-1:0]   mag_out
);

    logic signed [IN_WIDTH-1:0] s1_dat;
    logic                       s1_vld;
    logic signed [IN_WIDTH-1:0] s1_neg_dat;
    logic                       sat_hi;
    logic                       sat_lo;
    logic [OUT_WIDTH-1:0]       sat_dat;
    logic [MAG_WIDTH-1:0]       mag_dat;

    // Stage 1: capture the sample shifted by the shift present in its valid cycle.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= result_valid_in;
            if (result_valid_in)
                s1_dat <= $signed(result_in) >>> shift_in;
        end
    end

    // Saturation and capped magnitude; the cap test runs before negation so the
    // most-negative value never reaches the negate path.
    always_comb begin
        s1_neg_dat = -s1_dat;
        sat_hi     = (s1_dat > SAT_MAX);
        sat_lo     = (s1_dat < SAT_MIN);
        if (sat_hi)
            sat_dat = 16'h7FFF;
        else if (sat_lo)
            sat_dat = 16'h8000;
        else
            sat_dat = s1_dat[OUT_WIDTH-1:0];
        if ((s1_dat > PEAK_CAP_POS) || (s1_dat < PEAK_CAP_NEG))
            mag_dat = PEAK_CAP;
        else if (s1_dat[IN_WIDTH-1])
            mag_dat = s1_neg_dat[MAG_WIDTH-1:0];
        else
            mag_dat = s1_dat[MAG_WIDTH-1:0];
    end

    // Stage 2: register the saturated sample; audio_out holds between pulses.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            audio_out       <= '0;
            audio_valid_out <= 1'b0;
            clip_out        <= 1'b0;
            mag_out         <= '0;
        end else begin
            audio_valid_out <= s1_vld;
            clip_out        <= s1_vld & (sat_hi | sat_lo);
            if (s1_vld) begin
                audio_out <= sat_dat;
                mag_out   <= mag_dat;
            end
        end
    end

endmodule

// File: rtl/conv_output_agc.sv
// Scales convolution results to 16-bit audio with a windowed automatic gain control.
// Latency: 2 cycles from result_valid_in to audio_valid_out; gain updates once per window.
// Backpressure: none; the block accepts a sample on any cycle.
module conv_output_agc
    import audio_pkg::*;
#(
    parameter int WINDOW     = 2400,
    parameter int MIN_SHIFT  = 8,
    parameter int MAX_SHIFT  = 32,
    parameter int INIT_SHIFT = 16
) (
    input  logic        audio_clk,
    input  logic        rst_in,
    input  logic        audio_trigger,
    input  logic [47:0] result_in,
    input  logic        result_valid_in,
    input  logic        agc_enable_in,
    input  logic [5:0]  manual_shift_in,
    output logic [15:0] audio_out,
    output logic        audio_valid_out,
    output logic [5:0]  shift_out,
    output logic        clip_out
);

    localparam int                    CW       = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CW-1:0]         WIN_LAST = CW'(WINDOW - 1);
    localparam logic [SHIFT_WIDTH-1:0] MIN_S   = SHIFT_WIDTH'(MIN_SHIFT);
    localparam logic [SHIFT_WIDTH-1:0] MAX_S   = SHIFT_WIDTH'(MAX_SHIFT);
    localparam logic [SHIFT_WIDTH-1:0] INIT_S  = SHIFT_WIDTH'(INIT_SHIFT);

    agc_state_t             state;
    agc_state_t             state_nxt;
    logic [CW-1:0]          win_cnt;
    logic [SHIFT_WIDTH-1:0] agc_shift;
    logic [SHIFT_WIDTH-1:0] agc_shift_nxt;
    logic [SHIFT_WIDTH-1:0] manual_clamped;
    logic [SHIFT_WIDTH-1:0] eff_shift;
    logic [MAG_WIDTH-1:0]   peak;
    logic                   clip_flag;
    logic [MAG_WIDTH-1:0]   mag;

    // Effective shift is combinational so display and datapath see it immediately.
    always_comb begin
        manual_clamped = clamp_shift(manual_shift_in, MIN_S, MAX_S);
        eff_shift      = agc_enable_in ? agc_shift : manual_clamped;
        shift_out      = eff_shift;
    end

    sat_shifter u_sat_shifter (
        .audio_clk       (audio_clk),
        .rst_in          (rst_in),
        .result_in       (result_in),
        .result_valid_in (result_valid_in),
        .shift_in        (eff_shift),
        .audio_out       (audio_out),
        .audio_valid_out (audio_valid_out),
        .clip_out        (clip_out),
        .mag_out         (mag)
    );

    // FSM state and AGC shift registers.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            state     <= TRACK;
            agc_shift <= INIT_S;
        end else begin
            state     <= state_nxt;
            agc_shift <= agc_shift_nxt;
        end
    end

    // Next state and gain decision; with AGC off the register shadows the manual
    // value so enabling AGC starts from what the listener already hears.
    always_comb begin
        state_nxt     = state;
        agc_shift_nxt = agc_shift;
        case (state)
            TRACK: begin
                if (audio_trigger && (win_cnt == WIN_LAST))
                    state_nxt = EVAL;
            end
            EVAL: begin
                state_nxt = TRACK;
                if (clip_flag)
                    agc_shift_nxt = (agc_shift >= MAX_S) ? MAX_S : agc_shift + 6'd1;
                else if (peak < LOW_THRESH)
                    agc_shift_nxt = (agc_shift <= MIN_S) ? MIN_S : agc_shift - 6'd1;
            end
            default: state_nxt = TRACK;
        endcase
        if (!agc_enable_in)
            agc_shift_nxt = manual_clamped;
    end

    // Window counter advances on sample ticks while tracking.
    always_ff @(posedge audio_clk) begin
        if (rst_in)
            win_cnt <= '0;
        else if ((state == TRACK) && audio_trigger)
            win_cnt <= (win_cnt == WIN_LAST) ? '0 : win_cnt + CW'(1);
    end

    // Peak and sticky clip tracking; an output landing in EVAL seeds the new window.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            peak      <= '0;
            clip_flag <= 1'b0;
        end else if (audio_valid_out) begin
            if (state == EVAL) begin
                peak      <= mag;
                clip_flag <= clip_out;
            end else begin
                if (mag > peak)
                    peak <= mag;
                clip_flag <= clip_flag | clip_out;
            end
        end else if (state == EVAL) begin
            peak      <= '0;
            clip_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_output_agc.sv
// Self-checking bench for conv_output_agc: directed cases plus randomized traffic.
// Latency: checks outputs every cycle against a window-level behavioural model.
// Backpressure: none exercised; the DUT has no ready path.
module tb_conv_output_agc;

    localparam int WINDOW     = 4;
    localparam int MIN_SHIFT  = 8;
    // A ceiling of 24 lets a 2^40 input still clip at the top shift, so the
    // upper saturation of the gain step is reachable.
    localparam int MAX_SHIFT  = 24;
    localparam int INIT_SHIFT = 16;

    logic        audio_clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        audio_trigger = 1'b0;
    logic [47:0] result_in = '0;
    logic        result_valid_in = 1'b0;
    logic        agc_enable_in = 1'b1;
    logic [5:0]  manual_shift_in = 6'd16;
    logic [15:0] audio_out;
    logic        audio_valid_out;
    logic [5:0]  shift_out;
    logic        clip_out;

    int checks = 0;
    int errors = 0;

    always #5 audio_clk = ~audio_clk;

    conv_output_agc #(
        .WINDOW     (WINDOW),
        .MIN_SHIFT  (MIN_SHIFT),
        .MAX_SHIFT  (MAX_SHIFT),
        .INIT_SHIFT (INIT_SHIFT)
    ) dut (
        .audio_clk       (audio_clk),
        .rst_in          (rst_in),
        .audio_trigger   (audio_trigger),
        .result_in       (result_in),
        .result_valid_in (result_valid_in),
        .agc_enable_in   (agc_enable_in),
        .manual_shift_in (manual_shift_in),
        .audio_out       (audio_out),
        .audio_valid_out (audio_valid_out),
        .shift_out       (shift_out),
        .clip_out        (clip_out)
    );

    function automatic int clampf(input int s);
        if (s < MIN_SHIFT) return MIN_SHIFT;
        if (s > MAX_SHIFT) return MAX_SHIFT;
        return s;
    endfunction

    // ---------------- behavioural model ----------------
    // Samples in flight are tracked by the cycle on which they become visible;
    // window statistics are plain integers updated once per cycle.
    longint     pend_y[$];
    int         pend_at[$];
    int         cyc = 0;
    logic [15:0] m_out = '0;
    bit         m_vld = 0, m_clip = 0;
    longint     m_abs = 0;
    int         m_shift = INIT_SHIFT;
    int         ticks_in_window = 0;
    bit         eval_now = 0;
    longint     win_peak = 0;
    bit         win_clip = 0;

    always @(posedge audio_clk) begin
        int     eff;
        longint y;
        bit     landed;
        cyc++;
        if (rst_in) begin
            pend_y.delete(); pend_at.delete();
            m_out = '0; m_vld = 0; m_clip = 0; m_abs = 0;
            m_shift = INIT_SHIFT; ticks_in_window = 0; eval_now = 0;
            win_peak = 0; win_clip = 0;
        end else begin
            eff = agc_enable_in ? m_shift : clampf(int'(manual_shift_in));
            // gain decision uses statistics of the window that just closed
            if (!agc_enable_in)
                m_shift = clampf(int'(manual_shift_in));
            else if (eval_now) begin
                if (win_clip) m_shift = (m_shift < MAX_SHIFT) ? m_shift + 1 : MAX_SHIFT;
                else if (win_peak < 8192) m_shift = (m_shift > MIN_SHIFT) ? m_shift - 1 : MIN_SHIFT;
            end
            // the output visible during this cycle joins the statistics
            if (m_vld) begin
                if (eval_now) begin win_peak = m_abs; win_clip = m_clip; end
                else begin
                    if (m_abs > win_peak) win_peak = m_abs;
                    win_clip = win_clip | m_clip;
                end
            end else if (eval_now) begin
                win_peak = 0; win_clip = 0;
            end
            // window bookkeeping
            if (eval_now) eval_now = 0;
            else if (audio_trigger) begin
                ticks_in_window++;
                if (ticks_in_window == WINDOW) begin ticks_in_window = 0; eval_now = 1; end
            end
            // new sample, visible two edges from now
            if (result_valid_in) begin
                pend_y.push_back(longint'($signed(result_in)) >>> eff);
                pend_at.push_back(cyc + 1);
            end
            landed = 0;
            if (pend_at.size() > 0 && pend_at[0] == cyc) begin
                y = pend_y.pop_front(); void'(pend_at.pop_front());
                landed = 1;
                if (y > 32767) m_out = 16'h7FFF;
                else if (y < -32768) m_out = 16'h8000;
                else m_out = 16'(y);
                m_clip = (y > 32767) || (y < -32768);
                m_abs  = (y < 0) ? -y : y;
                if (m_abs > 65536) m_abs = 65536;
            end
            m_vld = landed;
            if (!landed) m_clip = 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    int fail_prints = 0;
    always @(negedge audio_clk) begin
        logic [5:0] exp_shift;
        exp_shift = 6'(agc_enable_in ? m_shift : clampf(int'(manual_shift_in)));
        checks++;
        if (audio_out !== m_out || audio_valid_out !== m_vld ||
            clip_out !== m_clip || shift_out !== exp_shift) begin
            errors++;
            if (fail_prints < 20)
                $display("FAIL model t=%0t out=%h/%h vld=%b/%b clip=%b/%b shift=%0d/%0d (got/expected)",
                         $time, audio_out, m_out, audio_valid_out, m_vld,
                         clip_out, m_clip, shift_out, exp_shift);
            fail_prints++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge audio_clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        result_valid_in = 1'b0;
        audio_trigger = 1'b0;
        repeat (2) tick();
        rst_in = 1'b0;
    endtask

    // One window of WINDOW triggers spaced three cycles apart, a sample on each
    // trigger; late_big moves the last sample to the cycle before the closing
    // trigger so its output lands in the EVAL cycle.
    task automatic run_window(input logic [47:0] val, input bit late_big);
        for (int i = 0; i < WINDOW; i++) begin
            audio_trigger   = 1'b1;
            result_valid_in = !(late_big && i == WINDOW - 1);
            result_in       = val;
            tick();
            audio_trigger   = 1'b0;
            result_valid_in = 1'b0;
            tick();
            if (late_big && i == WINDOW - 2) begin
                result_valid_in = 1'b1;
                result_in       = 48'h0100_0000_0000;
            end
            tick();
            result_valid_in = 1'b0;
        end
        tick();
    endtask

    function automatic logic [47:0] rand_result();
        logic [63:0]        r;
        logic signed [47:0] v;
        r = {$urandom, $urandom};
        v = r[47:0];
        case ($urandom_range(0, 9))
            0:       return 48'h8000_0000_0000;
            1:       return 48'h7FFF_FFFF_FFFF;
            default: return v >>> $urandom_range(0, 40);
        endcase
    endfunction

    initial begin
        int gap;
        rst_in = 1'b1;
        agc_enable_in = 1'b1;
        repeat (3) tick();
        chk("reset_out", audio_out, 0);
        chk("reset_vld", audio_valid_out, 0);
        chk("reset_clip", clip_out, 0);
        chk("reset_shift", shift_out, INIT_SHIFT);
        rst_in = 1'b0;

        // manual shift 16 on a mid-range value
        agc_enable_in = 1'b0; manual_shift_in = 6'd16;
        result_in = 48'h0000_1234_0000; result_valid_in = 1'b1;
        tick();
        result_valid_in = 1'b0;
        chk("lat1_novld", audio_valid_out, 0);
        tick();
        chk("man16_out", audio_out, 16'h1234);
        chk("man16_vld", audio_valid_out, 1);
        chk("man16_clip", clip_out, 0);
        tick();
        chk("hold_out", audio_out, 16'h1234);
        chk("hold_vld", audio_valid_out, 0);

        // manual shift below range clamps to MIN; negative overflow saturates
        manual_shift_in = 6'd3; #1;
        chk("clamp_lo", shift_out, MIN_SHIFT);
        result_in = 48'hFF00_0000_0000; result_valid_in = 1'b1;
        tick();
        result_valid_in = 1'b0;
        tick();
        chk("neg_sat_out", audio_out, 16'h8000);
        chk("neg_sat_clip", clip_out, 1);
        tick();
        chk("clip_pulse_end", clip_out, 0);
        manual_shift_in = 6'd40; #1;
        chk("clamp_hi", shift_out, MAX_SHIFT);

        // AGC climbs on clipping windows and saturates at MAX
        agc_enable_in = 1'b1;
        do_reset();
        run_window(48'h0100_0000_0000, 1'b0);
        chk("agc_up_first", shift_out, 17);
        repeat (12) run_window(48'h0100_0000_0000, 1'b0);
        chk("agc_up_max", shift_out, MAX_SHIFT);

        // AGC falls on quiet windows and saturates at MIN
        do_reset();
        run_window(48'h0000_0010_0000, 1'b0);
        chk("agc_dn_first", shift_out, 15);
        repeat (10) run_window(48'h0000_0010_0000, 1'b0);
        chk("agc_dn_min", shift_out, MIN_SHIFT);

        // an output landing in EVAL belongs to the next window
        do_reset();
        run_window(48'h0000_0010_0000, 1'b1);
        chk("eval_land_dn", shift_out, 15);
        run_window(48'h0000_0010_0000, 1'b0);
        chk("eval_land_carry", shift_out, 16);
        chk("pre_rst_out", audio_out, 16'd32);

        // reset between stage 1 and stage 2 discards the sample
        result_in = 48'h0100_0000_0000; result_valid_in = 1'b1;
        tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0; result_valid_in = 1'b0;
        chk("midrst_vld", audio_valid_out, 0);
        chk("midrst_out", audio_out, 0);
        chk("midrst_clip", clip_out, 0);
        chk("midrst_shift", shift_out, INIT_SHIFT);
        tick();
        chk("postrst_vld", audio_valid_out, 0);

        // randomized traffic, checked by the every-cycle model compare
        gap = 0;
        for (int c = 0; c < 4000; c++) begin
            gap++;
            audio_trigger = (gap >= 3) && ($urandom_range(0, 2) == 0);
            if (audio_trigger) gap = 0;
            result_valid_in = ($urandom_range(0, 2) == 0);
            result_in = rand_result();
            if ($urandom_range(0, 299) == 0) agc_enable_in = ~agc_enable_in;
            if ($urandom_range(0, 149) == 0) manual_shift_in = 6'($urandom_range(0, 63));
            rst_in = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst_in = 1'b0; result_valid_in = 1'b0; audio_trigger = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
